// File: rtl/demosaic_window_ctrl_pkg.sv
// Shared types for the demosaic window controller: FSM encoding, Bayer
// colour codes and the tag that travels with each 3x3 window.
package demosaic_window_ctrl_pkg;

    localparam int COORD_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        BAYER_R  = 2'd0,
        BAYER_GR = 2'd1,
        BAYER_GB = 2'd2,
        BAYER_B  = 2'd3
    } bayer_t;

    // Position and framing information registered alongside win_valid.
    typedef struct packed {
        logic [COORD_W-1:0] cx;
        logic [COORD_W-1:0] cy;
        logic [1:0]         phase;
        logic               sof;
        logic               eol;
        logic               eof;
    } win_tag_t;

    // The colour at (x,y) flips between R/Gr or Gb/B with column parity
    // and between the two rows with row parity, so XOR with the origin colour.
    function automatic logic [1:0] bayer_phase(input logic [1:0]         base,
                                               input logic [COORD_W-1:0] cx,
                                               input logic [COORD_W-1:0] cy);
        return base ^ {cy[0], cx[0]};
    endfunction

endpackage

// File: rtl/demosaic_pos_counter.sv
// Column/row position counter for a raster of IMG_W x IMG_H pixels.
// 'start' accepts pixel (0,0) and points at (1,0); 'advance' steps past
// the current pixel, wrapping at line and frame ends.
module demosaic_pos_counter
    import demosaic_window_ctrl_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               advance,
    output logic [COORD_W-1:0] col,
    output logic [COORD_W-1:0] row,
    output logic               frame_last
);

    logic col_last;
    logic row_last;

    assign col_last   = (col == COORD_W'(IMG_W - 1));
    assign row_last   = (row == COORD_W'(IMG_H - 1));
    assign frame_last = col_last && row_last;

    // Position update: restart wins over a normal step; the last pixel of
    // the frame wraps both coordinates back to the origin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (start) begin
            // NOTE: sequential state uses <= so every flop samples the
            // pre-edge values regardless of statement order.
            col <= COORD_W'(1);
            row <= '0;
        end else if (advance) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + COORD_W'(1);
            end else begin
                col <= col + COORD_W'(1);
            end
        end
    end

endmodule

// File: rtl/demosaic_window_ctrl.sv
// Control for a 3x3 demosaic window: decides when the window shift
// registers move, tracks the frame position and flags each window whose
// centre is an interior pixel together with its coordinates and colour.
module demosaic_window_ctrl
    import demosaic_window_ctrl_pkg::*;
#(
    parameter int         IMG_W = 640,
    parameter int         IMG_H = 480,
    parameter logic [1:0] BAYER = 2'd0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               in_sof,
    output logic               shift_en,
    output logic               win_valid,
    output logic [COORD_W-1:0] center_x,
    output logic [COORD_W-1:0] center_y,
    output logic [1:0]         phase,
    output logic               out_sof,
    output logic               out_eol,
    output logic               out_eof,
    output logic               busy,
    output logic               err_sof
);

    state_t             state;
    win_tag_t           tag;
    logic [COORD_W-1:0] col;
    logic [COORD_W-1:0] row;
    logic               frame_last;
    logic               cnt_start;
    logic               cnt_advance;
    logic               win_fire;
    logic [COORD_W-1:0] cx_next;
    logic [COORD_W-1:0] cy_next;

    // A frame (re)starts on any sof pixel while idle or mid-frame; ordinary
    // pixels only count while a frame is active.
    assign cnt_start   = in_valid && in_sof && (state == ST_IDLE || state == ST_ACTIVE);
    assign cnt_advance = in_valid && !in_sof && (state == ST_ACTIVE);

    // The window moves on every accepted pixel, including the sof pixel.
    assign shift_en = in_valid && (state == ST_ACTIVE || (state == ST_IDLE && in_sof));

    // Once pixel (col,row) with col,row >= 2 enters, the window is centred
    // one pixel up and to the left of it.
    assign win_fire = cnt_advance && (col >= COORD_W'(2)) && (row >= COORD_W'(2));
    assign cx_next  = col - COORD_W'(1);
    assign cy_next  = row - COORD_W'(1);

    demosaic_pos_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_pos (
        .clk        (clk),
        .rst        (rst),
        .start      (cnt_start),
        .advance    (cnt_advance),
        .col        (col),
        .row        (row),
        .frame_last (frame_last)
    );

    // Frame FSM plus registered window outputs; the tag holds its position
    // between windows while the framing pulses clear after one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            win_valid <= 1'b0;
            err_sof   <= 1'b0;
            tag       <= '0;
        end else begin
            win_valid <= win_fire;
            err_sof   <= in_valid && in_sof && (state == ST_ACTIVE);

            if (win_fire) begin
                tag.cx    <= cx_next;
                tag.cy    <= cy_next;
                tag.phase <= bayer_phase(BAYER, cx_next, cy_next);
                tag.sof   <= (cx_next == COORD_W'(1)) && (cy_next == COORD_W'(1));
                tag.eol   <= (cx_next == COORD_W'(IMG_W - 2));
                tag.eof   <= (cx_next == COORD_W'(IMG_W - 2)) && (cy_next == COORD_W'(IMG_H - 2));
            end else begin
                tag.sof <= 1'b0;
                tag.eol <= 1'b0;
                tag.eof <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (in_valid && in_sof) state <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (cnt_advance && frame_last) state <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign center_x = tag.cx;
    assign center_y = tag.cy;
    assign phase    = tag.phase;
    assign out_sof  = tag.sof;
    assign out_eol  = tag.eol;
    assign out_eof  = tag.eof;
    assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_demosaic_window_ctrl.sv
// Directed bench for demosaic_window_ctrl on a 4x4 frame, two instances
// differing only in the Bayer origin colour.
module tb_demosaic_window_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_sof = 1'b0;

    logic        shift_en0, win_valid0, out_sof0, out_eol0, out_eof0, busy0, err_sof0;
    logic [11:0] center_x0, center_y0;
    logic [1:0]  phase0;
    logic        shift_en1, win_valid1, out_sof1, out_eol1, out_eof1, busy1, err_sof1;
    logic [11:0] center_x1, center_y1;
    logic [1:0]  phase1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [11:0] cx;
        logic [11:0] cy;
        logic [1:0]  ph0;
        logic [1:0]  ph1;
        logic        s;
        logic        l;
        logic        e;
    } win_rec_t;

    win_rec_t wq[$];
    int       err_cnt    = 0;
    bit       shift_chk  = 1'b0;
    int       shift_mism = 0;

    always #5 clk = ~clk;

    demosaic_window_ctrl #(.IMG_W(4), .IMG_H(4), .BAYER(2'd0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
        .shift_en(shift_en0), .win_valid(win_valid0),
        .center_x(center_x0), .center_y(center_y0), .phase(phase0),
        .out_sof(out_sof0), .out_eol(out_eol0), .out_eof(out_eof0),
        .busy(busy0), .err_sof(err_sof0)
    );

    demosaic_window_ctrl #(.IMG_W(4), .IMG_H(4), .BAYER(2'd1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
        .shift_en(shift_en1), .win_valid(win_valid1),
        .center_x(center_x1), .center_y(center_y1), .phase(phase1),
        .out_sof(out_sof1), .out_eol(out_eol1), .out_eof(out_eof1),
        .busy(busy1), .err_sof(err_sof1)
    );

    // Record every window and error pulse, sampled away from the rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (win_valid0) begin
                wq.push_back('{cx: center_x0, cy: center_y0, ph0: phase0, ph1: phase1,
                               s: out_sof0, l: out_eol0, e: out_eof0});
            end
            if (err_sof0) err_cnt++;
            if (shift_chk && (shift_en0 !== in_valid)) shift_mism++;
        end
    end

    // One pixel presented for one clock; returns just after the accepting edge.
    task automatic send(input logic sof);
        in_valid = 1'b1;
        in_sof   = sof;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        logic [37:0] outs;
        #2;
        outs = {win_valid0, out_sof0, out_eol0, out_eof0, err_sof0, busy0, shift_en0,
                center_x0, center_y0, phase0, win_valid1, phase1};
        n_checks++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %0h expected 0", outs);
        end
        idle(2);
        rst = 1'b0;
        idle(1);
        n_checks++;
        if (busy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy_after_release: got %0b expected 0", busy0);
        end
    endtask

    task automatic test_back_to_back;
        int exp_cx[4]  = '{1, 2, 1, 2};
        int exp_cy[4]  = '{1, 1, 2, 2};
        int exp_ph0[4] = '{3, 2, 1, 0};
        int exp_ph1[4] = '{2, 3, 0, 1};
        int exp_s[4]   = '{1, 0, 0, 0};
        int exp_l[4]   = '{0, 1, 0, 1};
        int exp_e[4]   = '{0, 0, 0, 1};
        wq.delete();
        send(1'b1);
        n_checks++;
        if (busy0 !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_busy_after_sof: got %0b expected 1", busy0);
        end
        for (int i = 1; i < 16; i++) send(1'b0);
        n_checks++;
        if (busy0 !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_busy_in_flush: got %0b expected 1", busy0);
        end
        idle(1);
        n_checks++;
        if (busy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_busy_after_flush: got %0b expected 0", busy0);
        end
        idle(2);
        n_checks++;
        if (wq.size() !== 4) begin
            n_fail++;
            $display("FAIL b2b_window_count: got %0d expected 4", wq.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (wq[i].cx !== 12'(exp_cx[i]) || wq[i].cy !== 12'(exp_cy[i])) begin
                    n_fail++;
                    $display("FAIL b2b_centre[%0d]: got (%0d,%0d) expected (%0d,%0d)",
                             i, wq[i].cx, wq[i].cy, exp_cx[i], exp_cy[i]);
                end
                n_checks++;
                if ({wq[i].s, wq[i].l, wq[i].e} !== {1'(exp_s[i]), 1'(exp_l[i]), 1'(exp_e[i])}) begin
                    n_fail++;
                    $display("FAIL b2b_flags[%0d] sof/eol/eof: got %b%b%b expected %0d%0d%0d",
                             i, wq[i].s, wq[i].l, wq[i].e, exp_s[i], exp_l[i], exp_e[i]);
                end
                n_checks++;
                if (wq[i].ph0 !== 2'(exp_ph0[i]) || wq[i].ph1 !== 2'(exp_ph1[i])) begin
                    n_fail++;
                    $display("FAIL b2b_phase[%0d] bayer0/bayer1: got %0d/%0d expected %0d/%0d",
                             i, wq[i].ph0, wq[i].ph1, exp_ph0[i], exp_ph1[i]);
                end
            end
        end
    endtask

    task automatic test_gapped;
        int exp_cx[4] = '{1, 2, 1, 2};
        int exp_cy[4] = '{1, 1, 2, 2};
        wq.delete();
        shift_mism = 0;
        shift_chk  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send(i == 0);
            idle(1);
        end
        idle(2);
        shift_chk = 1'b0;
        n_checks++;
        if (shift_mism !== 0) begin
            n_fail++;
            $display("FAIL gap_shift_en_vs_in_valid: got %0d differing cycles expected 0", shift_mism);
        end
        n_checks++;
        if (wq.size() !== 4) begin
            n_fail++;
            $display("FAIL gap_window_count: got %0d expected 4", wq.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (wq[i].cx !== 12'(exp_cx[i]) || wq[i].cy !== 12'(exp_cy[i])) begin
                    n_fail++;
                    $display("FAIL gap_centre[%0d]: got (%0d,%0d) expected (%0d,%0d)",
                             i, wq[i].cx, wq[i].cy, exp_cx[i], exp_cy[i]);
                end
            end
        end
    endtask

    task automatic test_restart;
        wq.delete();
        err_cnt = 0;
        send(1'b1);
        for (int i = 1; i < 9; i++) send(1'b0);
        send(1'b1);
        n_checks++;
        if ({err_sof0, win_valid0, busy0} !== 3'b101) begin
            n_fail++;
            $display("FAIL restart_cycle err_sof/win_valid/busy: got %b%b%b expected 101",
                     err_sof0, win_valid0, busy0);
        end
        for (int i = 1; i < 16; i++) send(1'b0);
        idle(3);
        n_checks++;
        if (err_cnt !== 1) begin
            n_fail++;
            $display("FAIL restart_err_pulses: got %0d expected 1", err_cnt);
        end
        n_checks++;
        if (wq.size() !== 4) begin
            n_fail++;
            $display("FAIL restart_window_count: got %0d expected 4", wq.size());
        end else begin
            n_checks++;
            if (wq[0].cx !== 12'd1 || wq[0].cy !== 12'd1 || wq[0].s !== 1'b1) begin
                n_fail++;
                $display("FAIL restart_first_window: got (%0d,%0d) sof=%b expected (1,1) sof=1",
                         wq[0].cx, wq[0].cy, wq[0].s);
            end
            n_checks++;
            if (wq[3].e !== 1'b1) begin
                n_fail++;
                $display("FAIL restart_last_eof: got %b expected 1", wq[3].e);
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [37:0] outs;
        send(1'b1);
        for (int i = 1; i < 12; i++) send(1'b0);
        n_checks++;
        if (win_valid0 !== 1'b1 || center_x0 !== 12'd2 || center_y0 !== 12'd1) begin
            n_fail++;
            $display("FAIL pre_reset_window: got v=%b (%0d,%0d) expected v=1 (2,1)",
                     win_valid0, center_x0, center_y0);
        end
        #2;
        rst = 1'b1;
        #1;
        outs = {win_valid0, out_sof0, out_eol0, out_eof0, err_sof0, busy0, shift_en0,
                center_x0, center_y0, phase0, win_valid1, phase1};
        n_checks++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL midframe_reset_outputs: got %0h expected 0", outs);
        end
        #3;
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_no_sof;
        int bad_shift = 0;
        wq.delete();
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_sof   = 1'b0;
            #1;
            if (shift_en0 !== 1'b0) bad_shift++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        idle(2);
        n_checks++;
        if (bad_shift !== 0) begin
            n_fail++;
            $display("FAIL nosof_shift_en: got %0d cycles high expected 0", bad_shift);
        end
        n_checks++;
        if (wq.size() !== 0 || busy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL nosof_windows_busy: got %0d windows busy=%b expected 0 windows busy=0",
                     wq.size(), busy0);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gapped();
        test_restart();
        test_reset_mid_frame();
        test_no_sof();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/demosaic_window_ctrl.md
DEMOSAIC_WINDOW_CTRL -- requirements
Module: demosaic_window_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 640, active pixels per line (range 3..4095).
REQ-002 SHALL have parameter IMG_H, default 480, active lines per frame (range 3..4095).
REQ-003 SHALL have parameter BAYER, default 2'd0, colour of pixel (0,0): 0=R, 1=Gr, 2=Gb, 3=B.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: one raw pixel present on the buffer inputs this cycle.
REQ-007 SHALL have port in_sof, input, 1 bit: qualifies the first pixel of a frame; ignored unless in_valid.
REQ-008 SHALL have port shift_en, output, 1 bit: enable for the 3x3 window shift registers.
REQ-009 SHALL have port win_valid, output, 1 bit: the window registers hold a full interior 3x3 neighbourhood.
REQ-010 SHALL have port center_x, output, 12 bits: column of the window centre.
REQ-011 SHALL have port center_y, output, 12 bits: row of the window centre.
REQ-012 SHALL have port phase, output, 2 bits: Bayer colour at the centre, same encoding as BAYER.
REQ-013 SHALL have ports out_sof, out_eol and out_eof, each output, 1 bit: first, line-last and frame-last valid window.
REQ-014 SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-015 SHALL have port err_sof, output, 1 bit: one-cycle pulse when in_sof arrives mid-frame.

Function
REQ-016 SHALL implement FSM states IDLE, ACTIVE and FLUSH; IDLE is the reset state.
REQ-017 SHALL, in IDLE, ignore in_valid without in_sof.
REQ-018 SHALL, on in_valid&&in_sof in IDLE, accept that pixel as (0,0), then set col=1, row=0 and go to ACTIVE.
REQ-019 SHALL, in ACTIVE, on each in_valid increment col; at col==IMG_W-1 wrap col to 0 and increment row.
REQ-020 SHALL go to FLUSH on acceptance of pixel (IMG_W-1, IMG_H-1).
REQ-021 SHALL stay in FLUSH for exactly one cycle, then go to IDLE.
REQ-022 SHALL leave col/row unchanged in cycles with in_valid low (gaps of any length are legal).
REQ-023 SHALL drive shift_en combinationally as in_valid && (state==ACTIVE || (state==IDLE && in_sof)).
REQ-024 SHALL, in any other state or condition, hold shift_en low.
REQ-025 SHALL register win_valid with latency 1: it is high the cycle after accepting pixel (col,row) with col>=2 and row>=2.
REQ-026 SHALL make that win_valid cycle coincide with the window registers updating.
REQ-027 SHALL register center_x=col-1 and center_y=row-1 alongside win_valid.
REQ-028 SHALL compute phase = BAYER XOR {center_y[0], center_x[0]}.
REQ-029 SHALL pulse out_sof with the window centred (1,1).
REQ-030 SHALL pulse out_eol with each window where center_x==IMG_W-2.
REQ-031 SHALL pulse out_eof with the window centred (IMG_W-2, IMG_H-2).
REQ-032 SHALL hold center_x, center_y, phase and the out_* flags at their last values while win_valid is low; out_* pulses last one cycle.
REQ-033 SHALL, on in_valid&&in_sof while ACTIVE, pulse err_sof and restart the frame with that pixel as (0,0).
REQ-034 SHALL produce no win_valid on the restart cycle.
REQ-035 SHALL assert busy in ACTIVE and FLUSH only.

Reset
REQ-036 SHALL, on rst high, immediately force state=IDLE, col=0 and row=0.
REQ-037 SHALL, on rst high, immediately force win_valid, out_sof, out_eol, out_eof and err_sof to 0.
REQ-038 SHALL, on rst high, immediately force center_x, center_y and phase to 0.
REQ-039 SHALL discard any partial frame on reset mid-frame; the next frame requires in_sof.

Structure
REQ-040 SHALL place the FSM state encoding and Bayer colour codes in a shared demosaic package.
REQ-041 SHALL use one sub-module, demosaic_pos_counter (col/row counter with wrap and terminal flags).

Verification
REQ-042 SHALL verify: IMG_W=4, IMG_H=4, 16 back-to-back pixels with sof -> win_valid on 4 cycles, centres (1,1),(2,1),(1,2),(2,2); out_sof on the first, out_eol on the 2nd and 4th, out_eof on the 4th.
REQ-043 SHALL verify: same frame with in_valid low on every other cycle -> identical centre sequence, shift_en equal to in_valid.
REQ-044 SHALL verify: BAYER=0, centre (1,1) -> phase=3; centre (2,1) -> phase=2; BAYER=1, centre (1,1) -> phase=2.
REQ-045 SHALL verify: in_sof at pixel 9 of a 4x4 frame -> err_sof pulse, counters restart, next 16 pixels yield 4 windows.
REQ-046 SHALL verify: rst asserted mid-frame between clock edges -> all outputs 0 before the next edge, busy=0, pixels without sof ignored.
REQ-047 SHALL verify: pixels without in_sof after reset -> shift_en stays 0, no win_valid.
